// File: rtl/dmi_req_master_pkg.sv
// DMI request/response types and sticky error codes shared by the
// DTM-side DMI initiator and its environment.
package dmi_req_master_pkg;

  typedef enum logic [1:0] {
    DTM_NOP   = 2'd0,
    DTM_READ  = 2'd1,
    DTM_WRITE = 2'd2
  } dtm_op_e;

  localparam logic [1:0] DTM_SUCCESS = 2'd0;

  typedef struct packed {
    logic [6:0]  addr;
    dtm_op_e     op;
    logic [31:0] data;
  } dmi_req_t;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
  } dmi_resp_t;

  typedef enum logic [1:0] {
    DMINoError       = 2'd0,
    DMIReservedError = 2'd1,
    DMIOPFailed      = 2'd2,
    DMIBusy          = 2'd3
  } dmi_error_e;

endpackage

// File: rtl/dmi_req_master_if.sv
// DMI request/response channel between the DTM initiator and the
// debug module slave port.
interface dmi_req_master_if;
  import dmi_req_master_pkg::*;

  logic      dmi_req_valid_o;
  logic      dmi_req_ready_i;
  dmi_req_t  dmi_req_o;
  logic      dmi_resp_valid_i;
  logic      dmi_resp_ready_o;
  dmi_resp_t dmi_resp_i;

  modport master (
    output dmi_req_valid_o,
    output dmi_req_o,
    output dmi_resp_ready_o,
    input  dmi_req_ready_i,
    input  dmi_resp_valid_i,
    input  dmi_resp_i
  );

  modport slave (
    input  dmi_req_valid_o,
    input  dmi_req_o,
    input  dmi_resp_ready_o,
    output dmi_req_ready_i,
    output dmi_resp_valid_i,
    output dmi_resp_i
  );

endinterface

// File: rtl/dmi_req_master_timer.sv
// Response timeout counter for dmi_req_master; only instantiated
// when DMI_REQ_TIMEOUT_EN is defined.
module dmi_req_timer #(
  parameter int unsigned Cycles = 1024
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic run_i,
  output logic expire_o
);

  localparam int unsigned W = (Cycles > 2) ? $clog2(Cycles) : 1;

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      cnt_q <= '0;
    end else if (run_i) begin
      cnt_q <= cnt_q + W'(1);
    end
  end

  assign expire_o = run_i && (cnt_q == W'(Cycles - 1));

endmodule

// File: rtl/dmi_req_master.sv
// DTM-side DMI initiator: one outstanding request, sticky error status.
// Optional response timeout enabled by DMI_REQ_TIMEOUT_EN.
module dmi_req_master
  import dmi_req_master_pkg::*;
#(
  parameter int unsigned TimeoutCycles = 1024
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    update_i,
  input  dmi_req_t                upd_req_i,
  input  logic                    capture_i,
  output logic [40:0]             capture_o,
  input  logic                    dmireset_i,
  input  logic                    dmihardreset_i,
  dmi_req_master_if.master        dmi,
  output dmi_error_e              error_o
);

  typedef enum logic [2:0] {
    Idle,
    Read,
    Write,
    WaitReadResp,
    WaitWriteResp
  } state_e;

  state_e      state_q, state_d;
  dmi_error_e  error_q, error_d;
  logic [6:0]  addr_q, addr_d;
  dtm_op_e     op_q, op_d;
  logic [31:0] data_q, data_d;
  logic [40:0] capture_q;
  logic        busy;
  logic        err_busy;
  logic        err_fail;
  logic        expire;

  assign busy = (state_q != Idle);

`ifdef DMI_REQ_TIMEOUT_EN
  logic in_wait;
  assign in_wait = (state_q == WaitReadResp) ||
                   (state_q == WaitWriteResp);

  dmi_req_timer #(
    .Cycles   (TimeoutCycles)
  ) u_timer (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clear_i  (!in_wait),
    .run_i    (in_wait),
    .expire_o (expire)
  );
`else
  logic unused_timeout;
  assign unused_timeout = |TimeoutCycles;
  assign expire = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    op_d    = op_q;
    data_d  = data_q;
    err_busy = 1'b0;
    err_fail = 1'b0;
    dmi.dmi_req_valid_o  = 1'b0;
    dmi.dmi_resp_ready_o = 1'b0;
    unique case (state_q)
      Idle: begin
        dmi.dmi_resp_ready_o = 1'b1;
        if (update_i && error_q == DMINoError &&
            (upd_req_i.op == DTM_READ ||
             upd_req_i.op == DTM_WRITE)) begin
          addr_d  = upd_req_i.addr;
          op_d    = upd_req_i.op;
          data_d  = upd_req_i.data;
          state_d = (upd_req_i.op == DTM_READ) ?
                    Read : Write;
        end
      end
      Read, Write: begin
        dmi.dmi_req_valid_o = 1'b1;
        if (dmi.dmi_req_ready_i) begin
          state_d = (state_q == Read) ?
                    WaitReadResp : WaitWriteResp;
        end
      end
      WaitReadResp, WaitWriteResp: begin
        dmi.dmi_resp_ready_o = 1'b1;
        if (dmi.dmi_resp_valid_i) begin
          state_d = Idle;
          if (state_q == WaitReadResp) begin
            data_d = dmi.dmi_resp_i.data;
          end
          err_fail = (dmi.dmi_resp_i.resp != DTM_SUCCESS);
        end else if (expire) begin
          state_d  = Idle;
          err_fail = 1'b1;
        end
      end
      default: state_d = Idle;
    endcase

    if ((update_i || capture_i) && busy) begin
      err_busy = 1'b1;
    end

    // sticky: only the first error after a clear is recorded
    error_d = error_q;
    if (error_q == DMINoError) begin
      if (err_fail) begin
        error_d = DMIOPFailed;
      end else if (err_busy) begin
        error_d = DMIBusy;
      end
    end
    if (dmireset_i) begin
      error_d = DMINoError;
    end
    if (dmihardreset_i) begin
      state_d = Idle;
      error_d = DMINoError;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= Idle;
      error_q   <= DMINoError;
      addr_q    <= '0;
      op_q      <= DTM_NOP;
      data_q    <= '0;
      capture_q <= '0;
    end else begin
      state_q <= state_d;
      error_q <= error_d;
      addr_q  <= addr_d;
      op_q    <= op_d;
      data_q  <= data_d;
      if (capture_i) begin
        capture_q <= {addr_q, data_q,
                      busy ? DMIBusy : error_q};
      end
    end
  end

  assign dmi.dmi_req_o = {addr_q, op_q, data_q};
  assign capture_o     = capture_q;
  assign error_o       = error_q;

endmodule

// File: tb/tb_dmi_req_master.sv
// Randomized and directed bench for dmi_req_master against a
// transaction-level model of the DMI initiator.
module tb_dmi_req_master;
  import dmi_req_master_pkg::*;

  localparam int unsigned T = 8;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        update_i;
  logic [40:0] upd_req_i;
  logic        capture_i;
  logic [40:0] capture_o;
  logic        dmireset_i;
  logic        dmihardreset_i;
  dmi_error_e  error_o;

  dmi_req_master_if dmi();

  dmi_req_master #(
    .TimeoutCycles  (T)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .update_i       (update_i),
    .upd_req_i      (upd_req_i),
    .capture_i      (capture_i),
    .capture_o      (capture_o),
    .dmireset_i     (dmireset_i),
    .dmihardreset_i (dmihardreset_i),
    .dmi            (dmi),
    .error_o        (error_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // transaction-level model state
  bit          m_busy;
  bit          m_acc;
  bit          m_read;
  logic [40:0] m_req;
  logic [6:0]  m_addr;
  logic [31:0] m_data;
  logic [1:0]  m_err;
  logic [40:0] m_cap;
  int          m_wcnt;
  int          m_hs;
  int          dut_hs;

  task automatic step(input bit upd, input logic [40:0] rq,
                      input bit cap, input bit drst,
                      input bit hrst, input bit rdy,
                      input bit rv, input logic [33:0] rsp);
    bit exp_valid, bsy, fail, n_busy, n_acc;
    exp_valid = m_busy && !m_acc;
    check("valid", dmi.dmi_req_valid_o, exp_valid);
    if (exp_valid) check("req", dmi.dmi_req_o, m_req);
    check("resp_ready", dmi.dmi_resp_ready_o, !m_busy || m_acc);
    check("error", error_o, m_err);
    check("capture", capture_o, m_cap);
    if (dmi.dmi_req_valid_o && rdy) dut_hs++;

    update_i = upd; upd_req_i = rq; capture_i = cap;
    dmireset_i = drst; dmihardreset_i = hrst;
    dmi.dmi_req_ready_i = rdy;
    dmi.dmi_resp_valid_i = rv;
    dmi.dmi_resp_i = rsp;

    bsy = 0; fail = 0;
    n_busy = m_busy; n_acc = m_acc;
    if (cap) begin
      m_cap = {m_addr, m_data, m_busy ? 2'd3 : m_err};
      if (m_busy) bsy = 1;
    end
    if (exp_valid && rdy) begin
      n_acc = 1; m_wcnt = 0; m_hs++;
    end else if (m_busy && m_acc) begin
      if (rv) begin
        n_busy = 0;
        if (m_read) m_data = rsp[33:2];
        if (rsp[1:0] != 2'd0) fail = 1;
      end
`ifdef DMI_REQ_TIMEOUT_EN
      else if (m_wcnt == int'(T) - 1) begin
        n_busy = 0; fail = 1;
      end else begin
        m_wcnt++;
      end
`endif
    end
    if (upd) begin
      if (m_busy) bsy = 1;
      else if (m_err == 2'd0 &&
               (rq[33:32] == 2'd1 || rq[33:32] == 2'd2)) begin
        n_busy = 1; n_acc = 0;
        m_read = (rq[33:32] == 2'd1);
        m_addr = rq[40:34]; m_data = rq[31:0]; m_req = rq;
      end
    end
    if (m_err == 2'd0) begin
      if (fail) m_err = 2'd2;
      else if (bsy) m_err = 2'd3;
    end
    if (drst) m_err = 2'd0;
    if (hrst) begin n_busy = 0; m_err = 2'd0; end
    m_busy = n_busy; m_acc = n_acc;
    @(negedge clk);
  endtask

  task automatic idle(input bit rdy, input bit rv,
                      input logic [33:0] rsp);
    step(0, '0, 0, 0, 0, rdy, rv, rsp);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  logic [33:0] rsp_q[$];
  bit          rv_hold;
  bit          upd, cap, drst, hrst, rdy, vld_seen, rr_seen;
  logic [40:0] rq;
  logic [33:0] rsp;
  int          hs0, r;

  initial begin
    rst_i = 1; update_i = 0; upd_req_i = '0; capture_i = 0;
    dmireset_i = 0; dmihardreset_i = 0;
    dmi.dmi_req_ready_i = 0; dmi.dmi_resp_valid_i = 0;
    dmi.dmi_resp_i = '0;
    m_busy = 0; m_acc = 0; m_read = 0; m_req = '0;
    m_addr = '0; m_data = '0; m_err = '0; m_cap = '0;
    m_wcnt = 0; m_hs = 0; dut_hs = 0; rv_hold = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_valid", dmi.dmi_req_valid_o, 0);
    check("rst_req", dmi.dmi_req_o, 0);
    check("rst_capture", capture_o, 0);
    check("rst_error", error_o, 0);
    rst_i = 0;

    // read
    hs0 = dut_hs;
    step(1, {7'h11, 2'd1, 32'h0}, 0, 0, 0, 0, 0, '0);
    idle(1, 0, '0);
    idle(0, 0, '0);
    idle(0, 1, {32'h00400382, 2'd0});
    step(0, '0, 1, 0, 0, 0, 0, '0);
    idle(0, 0, '0);
    check("rd_capture", capture_o, {7'h11, 32'h00400382, 2'd0});
    check("rd_hs", dut_hs - hs0, 1);

    // write with ready held low
    hs0 = dut_hs;
    step(1, {7'h10, 2'd2, 32'h1}, 0, 0, 0, 0, 0, '0);
    repeat (5) begin
      check("wr_valid", dmi.dmi_req_valid_o, 1);
      check("wr_req", dmi.dmi_req_o, {7'h10, 2'd2, 32'h1});
      idle(0, 0, '0);
    end
    idle(1, 0, '0);
    idle(0, 1, {32'h0, 2'd0});
    check("wr_hs", dut_hs - hs0, 1);

    // busy
    hs0 = dut_hs;
    step(1, {7'h05, 2'd1, 32'h0}, 0, 0, 0, 0, 0, '0);
    idle(1, 0, '0);
    step(1, {7'h06, 2'd1, 32'h0}, 0, 0, 0, 0, 0, '0);
    idle(0, 1, {32'hdeadbeef, 2'd0});
    check("busy_err", error_o, 3);
    check("busy_hs", dut_hs - hs0, 1);
    step(0, '0, 1, 0, 0, 0, 0, '0);
    idle(0, 0, '0);
    check("busy_cap", capture_o[1:0], 3);
    step(0, '0, 0, 1, 0, 0, 0, '0);
    check("busy_clr", error_o, 0);
    step(1, {7'h07, 2'd2, 32'h55}, 0, 0, 0, 0, 0, '0);
    check("busy_new", dmi.dmi_req_valid_o, 1);
    idle(1, 0, '0);
    idle(0, 1, {32'h0, 2'd0});

    // failed
    step(1, {7'h08, 2'd1, 32'h0}, 0, 0, 0, 0, 0, '0);
    idle(1, 0, '0);
    idle(0, 1, {32'h0, 2'd2});
    check("fail_err", error_o, 2);
    step(1, {7'h09, 2'd2, 32'h3}, 0, 0, 0, 0, 0, '0);
    check("fail_ignored", dmi.dmi_req_valid_o, 0);
    step(0, '0, 0, 1, 0, 0, 0, '0);
    step(1, {7'h09, 2'd2, 32'h3}, 0, 0, 0, 0, 0, '0);
    check("fail_retry", dmi.dmi_req_valid_o, 1);
    idle(1, 0, '0);
    idle(0, 1, {32'h0, 2'd0});

    // hardreset mid-request, then stray response
    step(1, {7'h0a, 2'd1, 32'h0}, 0, 0, 0, 0, 0, '0);
    idle(0, 0, '0);
    step(0, '0, 0, 0, 1, 0, 0, '0);
    check("hr_valid", dmi.dmi_req_valid_o, 0);
    check("hr_err", error_o, 0);
    idle(0, 1, {32'hcafe, 2'd0});
    check("hr_rr", dmi.dmi_resp_ready_o, 1);
    step(0, '0, 1, 0, 0, 0, 0, '0);
    idle(0, 0, '0);

`ifdef DMI_REQ_TIMEOUT_EN
    step(1, {7'h0b, 2'd1, 32'h0}, 0, 0, 0, 0, 0, '0);
    idle(1, 0, '0);
    repeat (T) idle(0, 0, '0);
    check("to_err", error_o, 2);
    check("to_valid", dmi.dmi_req_valid_o, 0);
    step(0, '0, 0, 1, 0, 0, 0, '0);
`endif

    // randomized traffic with a valid/ready DM responder
    for (int i = 0; i < 3000; i++) begin
      upd  = ($urandom_range(0, 5) == 0);
      cap  = ($urandom_range(0, 7) == 0);
      drst = ($urandom_range(0, 19) == 0);
      hrst = ($urandom_range(0, 39) == 0);
      if (hrst) begin upd = 0; cap = 0; end
      rq[40:34] = 7'($urandom);
      rq[33:32] = 2'($urandom);
      rq[31:0]  = $urandom;
      rdy = ($urandom_range(0, 1) == 1);
      if (!rv_hold && rsp_q.size() > 0 &&
          $urandom_range(0, 2) == 0) rv_hold = 1;
      rsp = rv_hold ? rsp_q[0] : '0;
      vld_seen = dmi.dmi_req_valid_o;
      rr_seen  = dmi.dmi_resp_ready_o;
      step(upd, rq, cap, drst, hrst, rdy, rv_hold, rsp);
      if (vld_seen && rdy) begin
        r = $urandom_range(0, 9);
        rsp_q.push_back({$urandom,
                         (r == 0) ? 2'd2 : (r == 1) ? 2'd1 : 2'd0});
      end
      if (rv_hold && rr_seen) begin
        void'(rsp_q.pop_front());
        rv_hold = 0;
      end
    end
    check("hs_total", dut_hs, m_hs);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
